// File: rtl/front_multi.sv
// front_multi: multi-channel input front end.
//   Each asynchronous input is synchronized, then debounced by a digital
//   filter that accepts a new level only after it has been stable for
//   FILT_LEN consecutive cycles. Accepted transitions produce one-cycle
//   edge pulses; edges that match the per-channel mode set a sticky flag
//   and bump a saturating event counter.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   in        - [CH] asynchronous channel inputs
//   mode      - [2*CH] per-channel qualify mode (00 off, 01 rise, 10 fall, 11 both)
//   clr       - [CH] per-channel clear of flag and counter
//   pos_edge  - [CH] accepted 0->1 pulse
//   neg_edge  - [CH] accepted 1->0 pulse
//   any_edge  - [CH] pos_edge | neg_edge
//   flag      - [CH] sticky qualified-event flag
//   count     - [CH*CNT_W] saturating event counters, channel i at [i*CNT_W +: CNT_W]
//   irq       - OR of all flags
module front_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       in,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       pos_edge,
  output logic [CH-1:0]       neg_edge,
  output logic [CH-1:0]       any_edge,
  output logic [CH-1:0]       flag,
  output logic [CH*CNT_W-1:0] count,
  output logic                irq
);

  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]    sync_q [SYNC_STAGES];
  logic [CH-1:0]    sync_d [SYNC_STAGES];
  logic [CH-1:0]    s;

  logic [CH-1:0]    filt_q, filt_d;
  logic [CH-1:0]    val_q, val_d;
  logic [FC_W-1:0]  fc_q [CH];
  logic [FC_W-1:0]  fc_d [CH];
  logic [CH-1:0]    pos_q, pos_d;
  logic [CH-1:0]    neg_q, neg_d;

  logic [CH-1:0]    flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];

  // synchronizer chain; only the last stage is observed
  always_comb begin
    sync_d[0] = in;
    for (int j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // debounce filter: while not yet valid, fc free-runs so the first level
  // after reset is loaded FILT_LEN cycles later without any edge pulse
  always_comb begin
    filt_d = filt_q;
    val_d  = val_q;
    fc_d   = fc_q;
    pos_d  = '0;
    neg_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (val_q[i] && (s[i] == filt_q[i])) begin
        fc_d[i] = '0;
      end else if (fc_q[i] == FC_LAST) begin
        filt_d[i] = s[i];
        val_d[i]  = 1'b1;
        fc_d[i]   = '0;
        pos_d[i]  = val_q[i] & s[i];
        neg_d[i]  = val_q[i] & ~s[i];
      end else begin
        fc_d[i] = fc_q[i] + FC_W'(1);
      end
    end
  end

  // qualification acts on the pulse currently on the outputs, so flag and
  // count become visible the cycle after the pulse; an event coinciding
  // with clr restarts the count at 1 rather than being dropped
  always_comb begin
    logic [1:0] md;
    logic       qual;
    md     = '0;
    qual   = 1'b0;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < CH; i++) begin
      md   = mode[2*i +: 2];
      qual = ((md == 2'b01) && pos_q[i]) ||
             ((md == 2'b10) && neg_q[i]) ||
             ((md == 2'b11) && (pos_q[i] || neg_q[i]));
      if (qual) begin
        flag_d[i] = 1'b1;
        if (clr[i]) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (clr[i]) begin
        flag_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        fc_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      filt_q <= '0;
      val_q  <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
      flag_q <= '0;
    end else begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_d[j];
      end
      for (int i = 0; i < CH; i++) begin
        fc_q[i]  <= fc_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      filt_q <= filt_d;
      val_q  <= val_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
      flag_q <= flag_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < CH; i++) begin
      count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign pos_edge = pos_q;
  assign neg_edge = neg_q;
  assign any_edge = pos_q | neg_q;
  assign flag     = flag_q;
  assign irq      = |flag_q;

endmodule

// File: tb/tb_front_multi.sv
// tb_front_multi: scoreboard bench for front_multi (CH=4, SYNC_STAGES=2,
// FILT_LEN=3, CNT_W=4). A reference model steps on every rising edge and
// queues the expected outputs; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_front_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     in;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     pos_edge, neg_edge, any_edge, flag;
  logic [CH*CW-1:0]  count;
  logic              irq;

  front_multi #(.CH(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in(in), .mode(mode), .clr(clr),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .any_edge(any_edge),
    .flag(flag), .count(count), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    pos;
    logic [CH-1:0]    neg;
    logic [CH-1:0]    flg;
    logic [CH*CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  // ---------------- reference model ----------------
  logic [CH-1:0] pipe[$];       // synchronizer contents, newest at front
  bit            m_level[CH];   // accepted level
  bit            m_valid[CH];   // a level has been accepted since reset
  int            m_run[CH];     // cycles since acceptance during which s disagreed
  bit            m_pos[CH], m_neg[CH], m_flag[CH];
  int            m_cnt[CH];

  task automatic model_step();
    logic [CH-1:0] s;
    exp_t e;
    int md;
    bit qual, np, nn;
    if (rst) begin
      pipe.delete();
      for (int j = 0; j < SS; j++) pipe.push_back('0);
      for (int i = 0; i < CH; i++) begin
        m_level[i] = 0; m_valid[i] = 0; m_run[i] = 0;
        m_pos[i] = 0; m_neg[i] = 0; m_flag[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      s = pipe[SS-1];
      pipe.push_front(in);
      void'(pipe.pop_back());
      for (int i = 0; i < CH; i++) begin
        md = int'(mode[2*i +: 2]);
        qual = (md == 1 && m_pos[i]) || (md == 2 && m_neg[i]) ||
               (md == 3 && (m_pos[i] || m_neg[i]));
        if (qual) begin
          m_flag[i] = 1;
          m_cnt[i]  = clr[i] ? 1 : ((m_cnt[i] >= CMAX) ? CMAX : m_cnt[i] + 1);
        end else if (clr[i]) begin
          m_flag[i] = 0;
          m_cnt[i]  = 0;
        end
        np = 0; nn = 0;
        if (m_valid[i] && (s[i] == m_level[i])) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] == FL) begin
            if (m_valid[i]) begin
              np = s[i];
              nn = !s[i];
            end
            m_level[i] = s[i];
            m_valid[i] = 1;
            m_run[i]   = 0;
          end
        end
        m_pos[i] = np;
        m_neg[i] = nn;
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.pos[i] = m_pos[i];
      e.neg[i] = m_neg[i];
      e.flg[i] = m_flag[i];
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  function automatic void cmp(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, req);
    end
  endfunction

  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty at %0t: actual=0 expected=1 entries", $time);
      return;
    end
    e = exp_q.pop_front();
    cmp("pos_edge", 64'(pos_edge), 64'(e.pos));
    cmp("neg_edge", 64'(neg_edge), 64'(e.neg));
    cmp("any_edge", 64'(any_edge), 64'(e.pos | e.neg));
    cmp("flag",     64'(flag),     64'(e.flg));
    cmp("count",    64'(count),    64'(e.cnt));
    cmp("irq",      64'(irq),      64'(|e.flg));
  endtask

  initial forever begin
    @(negedge clk);
    if (!done) check();
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int ch, bit v, int n);
    in[ch] = v;
    cyc(n);
  endtask

  initial begin
    rst  = 1'b1;
    in   = '0;
    mode = 8'b01_01_01_01;
    clr  = '0;
    cyc(2);
    rst = 1'b0;
    cyc(10);

    // rising edge on ch0 under rising-only mode
    drive(0, 1, 10);

    // ch1: 2-cycle glitch rejected, then real pulse and fall
    drive(1, 1, 2);
    drive(1, 0, 8);
    drive(1, 1, 3);
    drive(1, 0, 10);

    // ch2 falling-only
    mode[5:4] = 2'b10;
    drive(2, 1, 6);
    drive(2, 0, 8);

    // ch3 both edges, saturate counter
    mode[7:6] = 2'b11;
    for (int p = 0; p < 20; p++) begin
      drive(3, 1, 6);
      drive(3, 0, 6);
    end
    cyc(4);

    // ch0: build count to 5, then clr on the incrementing clock, then clr alone
    mode[1:0] = 2'b11;
    drive(0, 0, 6);
    drive(0, 1, 6);
    drive(0, 0, 6);
    drive(0, 1, 6);
    in[0] = 1'b0;
    cyc(5);
    clr[0] = 1'b1;
    cyc(1);
    cyc(1);
    clr[0] = 1'b0;
    cyc(3);

    // reset while ch1 filter is counting
    in[1] = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    drive(1, 0, 8);

    // random phase without clear/reset so counters can saturate
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) in[i] = ~in[i];
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      cyc(1);
    end

    // random phase with everything
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) in[i] = ~in[i];
        clr[i] = ($urandom_range(0, 79) == 0);
      end
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      rst = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    rst = 1'b0;
    clr = '0;
    cyc(12);

    @(negedge clk);
    #1;
    done = 1;
    cmp("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/front_multi.md
FRONT_MULTI -- requirements
Module: front_multi

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flip-flops per channel (>=2).
REQ-003 Parameter FILT_LEN, default 3, consecutive stable cycles required to accept a level change (>=1; 1 = no filtering).
REQ-004 Parameter CNT_W, default 8, width of each per-channel event counter (>=2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in  input  CH  asynchronous channel inputs.
REQ-008 mode  input  2*CH  per-channel qualify mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 clr  input  CH  per-channel clear of flag and counter, sampled on clk.
REQ-010 pos_edge  output  CH  one-cycle pulse on accepted 0->1 transition.
REQ-011 neg_edge  output  CH  one-cycle pulse on accepted 1->0 transition.
REQ-012 any_edge  output  CH  pos_edge OR neg_edge per channel.
REQ-013 flag  output  CH  sticky per-channel event flag.
REQ-014 count  output  CH*CNT_W  per-channel saturating event counters, channel i at [i*CNT_W +: CNT_W].
REQ-015 irq  output  1  OR of all flag bits.

Function
REQ-016 Each in[i] SHALL pass through SYNC_STAGES flip-flops; output s[i] feeds filter only.
REQ-017 Per channel, filter SHALL hold filtered level filt[i], valid bit val[i], counter fc[i] (ceil(log2(FILT_LEN)) bits, min 1).
REQ-018 When s[i]==filt[i] and val[i]=1, fc[i] SHALL reset to 0 (glitch discarded).
REQ-019 When s[i]!=filt[i] or val[i]=0: fc[i] increments; at fc[i]==FILT_LEN-1, filt[i]<=s[i], fc[i]<=0, val[i]<=1.
REQ-020 Acceptance with val[i]=0 (first level after reset) SHALL load filt[i] without any edge pulse.
REQ-021 Acceptance with val[i]=1 SHALL register pos_edge[i] (new level 1) or neg_edge[i] (new level 0) high for exactly one cycle, same clock as filt[i] update.
REQ-022 Latency: input stable from before rising edge k -> pulse high in cycle following edge k+SYNC_STAGES+FILT_LEN-1 (defaults: after 5th edge counting k as 1st).
REQ-023 Input changes shorter than FILT_LEN cycles at s[i] SHALL produce no pulse.
REQ-024 pos/neg/any_edge SHALL be reported regardless of mode; mode only qualifies flag/count.
REQ-025 Qualified event: (mode 01 and pos_edge) or (mode 10 and neg_edge) or (mode 11 and any_edge); mode 00 never qualifies.
REQ-026 Qualified event SHALL set flag[i] and increment count[i] on the same clock, visible the cycle after the edge pulse.
REQ-027 count[i] SHALL saturate at 2^CNT_W-1; no wrap.
REQ-028 clr[i] without qualified event SHALL clear flag[i] and count[i] next cycle.
REQ-029 clr[i] coincident with qualified event: flag[i]=1, count[i]=1 (event never lost).
REQ-030 mode change SHALL take effect for events qualified on the same clock; no retroactive effect.
REQ-031 irq SHALL be combinational OR of flag; channels fully independent.

Reset
REQ-032 rst=1 at rising edge SHALL clear synchronizers, filt, val, fc, all edge outputs, flag, count; irq=0.
REQ-033 rst mid-filter or mid-pulse SHALL abort pending acceptance; after release first stable level is loaded per REQ-020 without pulse.
REQ-034 rst SHALL dominate clr, mode and in.

Verification (CH=4, SYNC_STAGES=2, FILT_LEN=3, CNT_W=4)
REQ-035 rst 2 cycles, in=0000 held 10 cycles, mode=01 all -> no pulses, flag=0000; then in[0]=1 held -> pos_edge[0]=any_edge[0]=1 for one cycle 5 edges later, next cycle flag=0001, count[0]=1, irq=1.
REQ-036 After init, in[1] high 2 cycles then low -> no pulse; in[1] high 3 cycles -> one pos_edge[1]; falling -> one neg_edge[1].
REQ-037 mode[5:4]=10, in[2] 0->1->0 each held 6 cycles -> pos_edge[2] and neg_edge[2] both pulse; flag[2] sets only after falling; count[2]=1.
REQ-038 mode[7:6]=11, 20 full pulses on in[3] (each level held 6 cycles) -> count[3] stops at 15, flag[3]=1.
REQ-039 clr[0] asserted on clock where count[0] increments from 5 -> flag[0]=1, count[0]=1; clr[0] alone next cycle -> flag[0]=0, count[0]=0, irq=0 if no other flags.
REQ-040 rst asserted one cycle while in[1] filter counting -> all outputs 0; after release, in[1] held stable -> no pulse; later change -> normal pulse.
